// File: rtl/matmul_seq_ctrl.sv
// Loop-nest sequencer for the matmul datapath: walks i/j/k for C = A * B, issues A/B
// reads and drives the MAC accumulate/clear strobes and the C write-back address.
module matmul_seq_ctrl #(
  parameter int unsigned M      = 4,
  parameter int unsigned N      = 4,
  parameter int unsigned K      = 4,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              mac_en,
  output logic              mac_first,
  output logic              c_we,
  output logic [ADDR_W-1:0] c_addr
);

  localparam int unsigned DW = (RD_LAT + 1 > 1) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [ADDR_W-1:0] MLast = ADDR_W'(M - 1);
  localparam logic [ADDR_W-1:0] NLast = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] KLast = ADDR_W'(K - 1);
  localparam logic [ADDR_W-1:0] NStep = ADDR_W'(N);
  localparam logic [DW-1:0]     DrainLast = DW'(RD_LAT);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic              armed_q, armed_d;
  logic [ADDR_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0] a_q, a_d, b_q, b_d, row_q, row_d, cc_q, cc_d;
  logic [DW-1:0]     cnt_q, cnt_d;
  logic              accept, last_rd;

  logic              rd_en_q, busy_q, done_q, c_we_q;
  logic [ADDR_W-1:0] c_addr_q;

  // Read-aligned tags shifted RD_LAT cycles to line up with returning read data.
  logic [RD_LAT-1:0] pe_q, pf_q, pl_q;
  logic [ADDR_W-1:0] pc_q [RD_LAT];

  // Next-state, start arming and loop counter / address stepping.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    row_d   = row_q;
    cc_d    = cc_q;
    cnt_d   = cnt_q;
    accept  = (state_q == StIdle) && start && armed_q;
    last_rd = (state_q == StRun) && (i_q == MLast) && (j_q == NLast) && (k_q == KLast);

    if (accept) begin
      armed_d = 1'b0;
    end else if (!start) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          a_d     = '0;
          b_d     = '0;
          row_d   = '0;
          cc_d    = '0;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (last_rd) begin
          state_d = StDrain;
        end else if (k_q != KLast) begin
          k_d = k_q + 1'b1;
          a_d = a_q + 1'b1;
          b_d = b_q + NStep;
        end else begin
          k_d  = '0;
          cc_d = cc_q + 1'b1;
          if (j_q != NLast) begin
            // Same row of A again, next column of B.
            j_d = j_q + 1'b1;
            a_d = row_q;
            b_d = j_q + 1'b1;
          end else begin
            // Next row of A starts right after the last element of this one.
            j_d   = '0;
            i_d   = i_q + 1'b1;
            a_d   = a_q + 1'b1;
            row_d = a_q + 1'b1;
            b_d   = '0;
          end
        end
      end
      StDrain: begin
        if (cnt_q == DrainLast) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control state, counters and state-derived output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      armed_q <= 1'b1;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      row_q   <= '0;
      cc_q    <= '0;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      row_q   <= row_d;
      cc_q    <= cc_d;
      cnt_q   <= cnt_d;
      rd_en_q <= (state_d == StRun);
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
    end
  end

  // Read-to-MAC delay line and C write-back stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_q     <= '0;
      pf_q     <= '0;
      pl_q     <= '0;
      for (int s = 0; s < RD_LAT; s++) pc_q[s] <= '0;
      c_we_q   <= 1'b0;
      c_addr_q <= '0;
    end else begin
      pe_q[0] <= rd_en_q;
      pf_q[0] <= rd_en_q && (k_q == '0);
      pl_q[0] <= rd_en_q && (k_q == KLast);
      pc_q[0] <= cc_q;
      for (int s = 1; s < RD_LAT; s++) begin
        pe_q[s] <= pe_q[s-1];
        pf_q[s] <= pf_q[s-1];
        pl_q[s] <= pl_q[s-1];
        pc_q[s] <= pc_q[s-1];
      end
      c_we_q <= pl_q[RD_LAT-1];
      if (pl_q[RD_LAT-1]) c_addr_q <= pc_q[RD_LAT-1];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign a_addr    = a_q;
  assign b_addr    = b_q;
  assign mac_en    = pe_q[RD_LAT-1];
  assign mac_first = pf_q[RD_LAT-1];
  assign c_we      = c_we_q;
  assign c_addr    = c_addr_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: default 4x4x4 instance plus a K=1 / RD_LAT=2 instance.
module tb_matmul_seq_ctrl;

  localparam int M0 = 4, N0 = 4, K0 = 4, R0 = 1;
  localparam int M1 = 2, N1 = 3, K1 = 1, R1 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;

  logic       busy0, done0, rd_en0, mac_en0, mac_first0, c_we0;
  logic [7:0] a0, b0, c0;
  logic       busy1, done1, rd_en1, mac_en1, mac_first1, c_we1;
  logic [7:0] a1, b1, c1;

  int checks = 0;
  int errors = 0;

  logic [15:0] rdq0[$], rdq1[$];
  logic [7:0]  cq0[$], cq1[$];

  always #5 clk = ~clk;

  matmul_seq_ctrl #(.M(M0), .N(N0), .K(K0), .RD_LAT(R0), .ADDR_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0), .rd_en(rd_en0),
    .a_addr(a0), .b_addr(b0), .mac_en(mac_en0), .mac_first(mac_first0), .c_we(c_we0),
    .c_addr(c0)
  );

  matmul_seq_ctrl #(.M(M1), .N(N1), .K(K1), .RD_LAT(R1), .ADDR_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .rd_en(rd_en1),
    .a_addr(a1), .b_addr(b1), .mac_en(mac_en1), .mac_first(mac_first1), .c_we(c_we1),
    .c_addr(c1)
  );

  // Expected {busy, done, rd_en, mac_en, mac_first, c_we} at cycle t after the start sample.
  function automatic logic [5:0] exp_ctrl(input int t, input int m, input int n, input int k,
                                          input int r);
    int  l;
    bit  bsy, dn, rd, mac, fst, cwe;
    l   = m * n * k;
    rd  = (t >= 1) && (t <= l);
    mac = (t >= 1 + r) && (t <= l + r);
    fst = mac && (((t - 1 - r) % k) == 0);
    cwe = ((t - 1) >= 1 + r) && ((t - 1) <= l + r) && (((t - 2 - r) % k) == k - 1);
    dn  = (t == l + r + 2);
    bsy = (t >= 1) && (t <= l + r + 2);
    return {bsy, dn, rd, mac, fst, cwe};
  endfunction

  task automatic fill_expected0();
    rdq0.delete();
    cq0.delete();
    for (int i = 0; i < M0; i++)
      for (int j = 0; j < N0; j++) begin
        for (int k = 0; k < K0; k++) rdq0.push_back({8'(i * K0 + k), 8'(k * N0 + j)});
        cq0.push_back(8'(i * N0 + j));
      end
  endtask

  // Runs one job on dut0; start is high for cycles < hold_until and at pulse_at.
  task automatic observe_job0(input int ncyc, input int hold_until, input int pulse_at,
                              input string name);
    logic [5:0]  act, exp;
    logic [15:0] e;
    logic [7:0]  ec;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= ncyc; t++) begin
      #1;
      act = {busy0, done0, rd_en0, mac_en0, mac_first0, c_we0};
      exp = exp_ctrl(t, M0, N0, K0, R0);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s ctrl cycle %0d: got %b expected %b", name, t, act, exp);
      end
      if (rd_en0 === 1'b1) begin
        checks++;
        if (rdq0.size() == 0) begin
          errors++;
          $display("FAIL %s extra read cycle %0d: got a=%0d b=%0d expected none", name, t, a0, b0);
        end else begin
          e = rdq0.pop_front();
          if ({a0, b0} !== e) begin
            errors++;
            $display("FAIL %s rd addr cycle %0d: got a=%0d b=%0d expected a=%0d b=%0d",
                     name, t, a0, b0, e[15:8], e[7:0]);
          end
        end
      end
      if (c_we0 === 1'b1) begin
        checks++;
        if (cq0.size() == 0) begin
          errors++;
          $display("FAIL %s extra c_we cycle %0d: got c=%0d expected none", name, t, c0);
        end else begin
          ec = cq0.pop_front();
          if (c0 !== ec) begin
            errors++;
            $display("FAIL %s c_addr cycle %0d: got %0d expected %0d", name, t, c0, ec);
          end
        end
      end
      start0 = (t < hold_until) || (t == pulse_at);
      @(posedge clk);
    end
    checks++;
    if (rdq0.size() != 0 || cq0.size() != 0) begin
      errors++;
      $display("FAIL %s leftover: got %0d reads %0d writes pending expected 0 0",
               name, rdq0.size(), cq0.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy0, done0, rd_en0, mac_en0, mac_first0, c_we0, a0, b0, c0} !== '0) begin
      errors++;
      $display("FAIL reset dut0: got %b expected all zero",
               {busy0, done0, rd_en0, mac_en0, mac_first0, c_we0, a0, b0, c0});
    end
    checks++;
    if ({busy1, done1, rd_en1, mac_en1, mac_first1, c_we1, a1, b1, c1} !== '0) begin
      errors++;
      $display("FAIL reset dut1: got %b expected all zero",
               {busy1, done1, rd_en1, mac_en1, mac_first1, c_we1, a1, b1, c1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic_job();
    fill_expected0();
    observe_job0(72, 1, -1, "basic");
  endtask

  task automatic test_start_held();
    fill_expected0();
    observe_job0(200, 200, -1, "held");
    fill_expected0();
    observe_job0(72, 1, -1, "rearm");
  endtask

  task automatic test_start_while_busy();
    fill_expected0();
    observe_job0(80, 1, 10, "busy_pulse");
  endtask

  task automatic test_k1();
    logic [5:0]  act, exp;
    logic [15:0] e;
    logic [7:0]  ec;
    rdq1.delete();
    cq1.delete();
    for (int i = 0; i < M1; i++)
      for (int j = 0; j < N1; j++) begin
        rdq1.push_back({8'(i), 8'(j)});
        cq1.push_back(8'(i * N1 + j));
      end
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= 16; t++) begin
      #1;
      act = {busy1, done1, rd_en1, mac_en1, mac_first1, c_we1};
      exp = exp_ctrl(t, M1, N1, K1, R1);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL k1 ctrl cycle %0d: got %b expected %b", t, act, exp);
      end
      if (rd_en1 === 1'b1) begin
        checks++;
        if (rdq1.size() == 0) begin
          errors++;
          $display("FAIL k1 extra read cycle %0d: got a=%0d b=%0d expected none", t, a1, b1);
        end else begin
          e = rdq1.pop_front();
          if ({a1, b1} !== e) begin
            errors++;
            $display("FAIL k1 rd addr cycle %0d: got a=%0d b=%0d expected a=%0d b=%0d",
                     t, a1, b1, e[15:8], e[7:0]);
          end
        end
      end
      if (c_we1 === 1'b1) begin
        checks++;
        if (cq1.size() == 0) begin
          errors++;
          $display("FAIL k1 extra c_we cycle %0d: got c=%0d expected none", t, c1);
        end else begin
          ec = cq1.pop_front();
          if (c1 !== ec) begin
            errors++;
            $display("FAIL k1 c_addr cycle %0d: got %0d expected %0d", t, c1, ec);
          end
        end
      end
      start1 = 1'b0;
      @(posedge clk);
    end
    checks++;
    if (rdq1.size() != 0 || cq1.size() != 0) begin
      errors++;
      $display("FAIL k1 leftover: got %0d reads %0d writes pending expected 0 0",
               rdq1.size(), cq1.size());
    end
  endtask

  task automatic test_reset_mid_job();
    logic [29:0] outs;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    for (int t = 1; t < 30; t++) begin
      #1;
      if (t == 29) begin
        checks++;
        if (busy0 !== 1'b1 || rd_en0 !== 1'b1) begin
          errors++;
          $display("FAIL midrst pre busy/rd_en: got %b%b expected 11", busy0, rd_en0);
        end
      end
      start0 = 1'b0;
      @(posedge clk);
    end
    #1;
    rst_n = 1'b0;
    for (int t = 30; t <= 80; t++) begin
      #1;
      outs = {busy0, done0, rd_en0, mac_en0, mac_first0, c_we0, a0, b0, c0};
      checks++;
      if (outs !== '0) begin
        errors++;
        $display("FAIL midrst outputs cycle %0d: got %b expected all zero", t, outs);
      end
      if (t == 35) rst_n = 1'b1;
      @(posedge clk);
      #1;
    end
    fill_expected0();
    observe_job0(72, 1, -1, "after_rst");
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_start_held();
    test_start_while_busy();
    test_k1();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
